// File: rtl/mod_arith_pkg.sv
// Shared encodings and helpers for the runtime-modulus arithmetic unit.
package mod_arith_pkg;

    typedef enum logic [1:0] {
        OP_MUL = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Largest multiplier-bit count per cycle the step chain supports.
    localparam int unsigned BPC_MAX = 4;

    function automatic logic bpc_legal(input int unsigned bpc);
        return (bpc == 1) || (bpc == 2) || (bpc == BPC_MAX);
    endfunction

endpackage

// File: rtl/mod_dbl_add_step.sv
// One double-and-add step: res = (2*acc + b_bit*a) mod p, given acc < p and a < p.
module mod_dbl_add_step
    import mod_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 128
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] p,
    input  logic             b_bit,
    output logic [WIDTH-1:0] res
);

    localparam int unsigned XW = WIDTH + 2;

    logic [XW-1:0] p_x;
    logic [XW-1:0] t0;
    logic [XW-1:0] t1;

    // Intermediate is below 3p, so two conditional subtractions suffice.
    always_comb begin
        p_x = {2'b00, p};
        t0  = {1'b0, acc, 1'b0} + (b_bit ? {2'b00, a} : XW'(0));
        t1  = (t0 >= p_x) ? (t0 - p_x) : t0;
        res = WIDTH'((t1 >= p_x) ? (t1 - p_x) : t1);
    end

endmodule

// File: rtl/mod_mul_stream.sv
// Streaming modular MUL/ADD/SUB with a per-request modulus, tag pass-through and range checking.
module mod_mul_stream
    import mod_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned BPC   = 1,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_mod,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_r,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             busy
);

    localparam int unsigned N_MUL = WIDTH / BPC;
    localparam int unsigned CNT_W = $clog2(N_MUL) + 1;

    if (!bpc_legal(BPC) || (WIDTH % BPC) != 0) begin : g_bad_bpc
        $error("mod_mul_stream: BPC must be 1, 2 or 4 and divide WIDTH");
    end

    state_e           state;
    op_e              op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] acc_q;
    logic [TAG_W-1:0] tag_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             in_err;
    logic [BPC:0][WIDTH-1:0] chain;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] addsub;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign in_err   = (in_mod < WIDTH'(2)) || (in_a >= in_mod) || (in_b >= in_mod)
                    || (in_op == OP_RSV);

    // BPC double-and-add steps per cycle, consuming b MSB-first.
    assign chain[0] = acc_q;
    for (genvar i = 0; i < BPC; i++) begin : g_step
        mod_dbl_add_step #(.WIDTH(WIDTH)) u_step (
            .acc   (chain[i]),
            .a     (a_q),
            .p     (p_q),
            .b_bit (b_q[WIDTH-1-i]),
            .res   (chain[i+1])
        );
    end

    // Single-cycle modular add/subtract on the latched operands.
    always_comb begin
        sum_w = {1'b0, a_q} + {1'b0, b_q};
        if (sum_w >= {1'b0, p_q}) begin
            sum_w = sum_w - {1'b0, p_q};
        end
        diff_w = {1'b0, a_q} - {1'b0, b_q};
        if (a_q < b_q) begin
            diff_w = diff_w + {1'b0, p_q};
        end
        addsub = (op_q == OP_ADD) ? WIDTH'(sum_w) : WIDTH'(diff_w);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= OP_MUL;
            a_q       <= '0;
            b_q       <= '0;
            p_q       <= '0;
            acc_q     <= '0;
            tag_q     <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_tag   <= '0;
            out_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        // Errored requests still spend one RUN cycle so they share ADD/SUB timing.
                        state     <= RUN;
                        op_q      <= op_e'(in_op);
                        a_q       <= in_a;
                        b_q       <= in_b;
                        p_q       <= in_mod;
                        acc_q     <= '0;
                        tag_q     <= in_tag;
                        err_q     <= in_err;
                        cnt_q     <= (!in_err && in_op == OP_MUL) ? CNT_W'(N_MUL - 1) : '0;
                        out_valid <= 1'b0;
                        busy      <= 1'b1;
                    end else if (state == DONE && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                RUN: begin
                    acc_q <= chain[BPC];
                    b_q   <= b_q << BPC;
                    if (cnt_q == '0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_tag   <= tag_q;
                        out_err   <= err_q;
                        if (err_q) begin
                            out_r <= '0;
                        end else if (op_q == OP_MUL) begin
                            out_r <= chain[BPC];
                        end else begin
                            out_r <= addsub;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
